obs_ctrl: RTL

OBS_CTRL -- requirements
Module: obs_ctrl

---
 rtl/obs_ctrl_pkg.sv | 50 +++++
 rtl/obs_lfsr.sv | 25 ++
 rtl/obs_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/obs_ctrl_pkg.sv
// Shared definitions for the obstacle controller: FSM encoding, screen and
// obstacle geometry, the erase colour, and the LFSR step/row-mapping helpers.
package obs_ctrl_pkg;

   typedef enum logic [2:0] {
      INIT_DRAW = 3'd0,
      WAIT_TICK = 3'd1,
      ERASE     = 3'd2,
      MOVE      = 3'd3,
      DRAW_REQ  = 3'd4,
      DRAW_BUSY = 3'd5,
      DRAW_WAIT = 3'd6
   } state_t;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int OBS_W    = 3;
   localparam int OBS_H    = 10;
   localparam int Y_MIN    = 3;
   localparam int Y_MAX    = 113;

   // The obstacle anchor sits 3 rows below the top of its 3x10 footprint.
   localparam int Y_TOP_OFS = 3;
   // Pixels in one erase pass (column-major over the footprint).
   localparam int ERASE_PIX = OBS_W * OBS_H;
   // Amount subtracted from LFSR values above Y_MAX to fold them back on screen.
   localparam int ROW_FOLD  = 14;

   localparam logic [2:0] BLACK     = 3'b000;
   localparam logic [6:0] LFSR_SEED = 7'h5A;

   // One step of the 7-bit Fibonacci LFSR, polynomial x^7 + x^6 + 1.
   function automatic logic [6:0] lfsr_next(input logic [6:0] q);
      return {q[5:0], q[6] ^ q[5]};
   endfunction

   // Fold a nonzero LFSR value into the legal anchor-row range Y_MIN..Y_MAX.
   function automatic logic [6:0] map_row(input logic [6:0] v);
      logic [6:0] r;
      if (v < 7'(Y_MIN)) begin
         r = v + 7'(Y_MIN);
      end else if (v > 7'(Y_MAX)) begin
         r = v - 7'(ROW_FOLD);
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/obs_lfsr.sv
// Free-running 7-bit LFSR that supplies the row for a freshly wrapped obstacle.
// The register never reaches zero because it starts from a nonzero seed and
// the polynomial is maximal-length.
module obs_lfsr
   import obs_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   output logic [6:0] row
);

   logic [6:0] lfsr;

   // Advance the sequence every cycle; restart from the seed on reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   assign row = map_row(lfsr);

endmodule

// File: rtl/obs_ctrl.sv
// Obstacle controller: scrolls one obstacle leftward across the screen. Each
// movement tick it erases the old 3x10 footprint pixel by pixel, moves the
// anchor, and hands the new position to an external drawer. Wrapping off the
// left edge respawns the obstacle at X_START on a pseudo-random row and emits
// a one-cycle score pulse.
module obs_ctrl
   import obs_ctrl_pkg::*;
#(
   parameter int FRAME_DIV = 833333,
   parameter int X_START   = 159,
   parameter int STEP      = 1,
   parameter int Y_INIT    = 60
)(
   input  logic       clock,
   input  logic       resetn,
   input  logic       run,
   input  logic       draw_done,
   output logic [7:0] obs_x,
   output logic [6:0] obs_y,
   output logic       draw_start,
   output logic [7:0] erase_x,
   output logic [6:0] erase_y,
   output logic [2:0] erase_color,
   output logic       erase_en,
   output logic       bus_sel,
   output logic       pass_pulse
);

   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
   localparam logic [4:0] PIX_LAST = 5'(ERASE_PIX - 1);

   state_t           state;
   logic [DIV_W-1:0] div;
   logic [4:0]       pix;
   logic [6:0]       lfsr_row;

   obs_lfsr u_lfsr (
      .clock  (clock),
      .resetn (resetn),
      .row    (lfsr_row)
   );

   // Sequencer: tick divider, erase walk, move, and drawer handshake, with
   // every output registered alongside the state it belongs to.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= INIT_DRAW;
         div         <= '0;
         pix         <= 5'd0;
         obs_x       <= 8'(X_START);
         obs_y       <= 7'(Y_INIT);
         draw_start  <= 1'b0;
         erase_x     <= 8'd0;
         erase_y     <= 7'd0;
         erase_color <= 3'b000;
         erase_en    <= 1'b0;
         bus_sel     <= 1'b0;
         pass_pulse  <= 1'b0;
      end else begin
         erase_color <= BLACK;
         case (state)
            INIT_DRAW: begin
               // First draw uses the reset position; nothing to erase yet.
               state      <= DRAW_REQ;
               draw_start <= 1'b1;
            end

            WAIT_TICK: begin
               if (run) begin
                  if (div == DIV_LAST) begin
                     div      <= '0;
                     state    <= ERASE;
                     pix      <= 5'd0;
                     erase_en <= 1'b1;
                     bus_sel  <= 1'b1;
                     erase_x  <= obs_x;
                     erase_y  <= obs_y - 7'(Y_TOP_OFS);
                  end else begin
                     div <= div + DIV_W'(1);
                  end
               end else begin
                  // Paused: the divider keeps its count until run returns.
                  div <= div;
               end
            end

            ERASE: begin
               if (pix == PIX_LAST) begin
                  state    <= MOVE;
                  erase_en <= 1'b0;
                  bus_sel  <= 1'b0;
               end else begin
                  pix <= pix + 5'd1;
                  // Column-major walk: bottom row of a column steps to the
                  // top of the next column. x wraps modulo 256 by design.
                  if (erase_y == obs_y + 7'(OBS_H - Y_TOP_OFS - 1)) begin
                     erase_x <= erase_x + 8'd1;
                     erase_y <= obs_y - 7'(Y_TOP_OFS);
                  end else begin
                     erase_y <= erase_y + 7'd1;
                  end
               end
            end

            MOVE: begin
               if (obs_x < 8'(STEP)) begin
                  obs_x      <= 8'(X_START);
                  obs_y      <= lfsr_row;
                  pass_pulse <= 1'b1;
               end else begin
                  obs_x      <= obs_x - 8'(STEP);
                  pass_pulse <= 1'b0;
               end
               state      <= DRAW_REQ;
               draw_start <= 1'b1;
            end

            DRAW_REQ: begin
               draw_start <= 1'b0;
               pass_pulse <= 1'b0;
               state      <= DRAW_BUSY;
            end

            DRAW_BUSY: begin
               // The drawer drops done when it accepts the job; no timeout.
               if (!draw_done) begin
                  state <= DRAW_WAIT;
               end else begin
                  state <= DRAW_BUSY;
               end
            end

            DRAW_WAIT: begin
               if (draw_done) begin
                  state <= WAIT_TICK;
               end else begin
                  state <= DRAW_WAIT;
               end
            end

            default: begin
               state      <= INIT_DRAW;
               div        <= '0;
               pix        <= 5'd0;
               draw_start <= 1'b0;
               erase_en   <= 1'b0;
               bus_sel    <= 1'b0;
               pass_pulse <= 1'b0;
            end
         endcase
      end
   end

endmodule
